// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the I/D caches, the memory line port and the arbiter.
// The arbiter takes the slave view; the cache/memory environment takes the master view.
interface cache_mem_arbiter_if #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
);
    logic                  i_read;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [LINE_WIDTH-1:0] i_rdata;
    logic                  i_resp;

    logic                  d_read;
    logic                  d_write;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic [LINE_WIDTH-1:0] d_rdata;
    logic                  d_resp;

    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    logic                  busy;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write,
               pmem_address, pmem_wdata, busy
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write,
               pmem_address, pmem_wdata, busy
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one memory line port between the instruction and data caches.
// Every output is a register; the DONE state gives requesters a cycle to drop a served request.
module cache_mem_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    cache_mem_arbiter_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    state_e                state_r, state_next_s;
    logic                  last_grant_d_r, last_grant_d_next_s;
    logic                  pmem_read_r, pmem_read_next_s;
    logic                  pmem_write_r, pmem_write_next_s;
    logic [ADDR_WIDTH-1:0] pmem_address_r, pmem_address_next_s;
    logic [LINE_WIDTH-1:0] pmem_wdata_r, pmem_wdata_next_s;
    logic [LINE_WIDTH-1:0] i_rdata_r, i_rdata_next_s;
    logic [LINE_WIDTH-1:0] d_rdata_r, d_rdata_next_s;
    logic                  i_resp_r, i_resp_next_s;
    logic                  d_resp_r, d_resp_next_s;
    logic                  busy_r;
    logic                  req_i_s, req_d_s, grant_i_s, grant_d_s;

    assign req_i_s   = bus.i_read;
    assign req_d_s   = bus.d_read | bus.d_write;
    // On a tie, I wins only if D had the previous grant.
    assign grant_i_s = req_i_s & (~req_d_s | last_grant_d_r);
    assign grant_d_s = req_d_s & ~grant_i_s;

    // Next-state and next-output computation for the arbiter FSM.
    always_comb begin
        state_next_s        = state_r;
        last_grant_d_next_s = last_grant_d_r;
        pmem_read_next_s    = pmem_read_r;
        pmem_write_next_s   = pmem_write_r;
        pmem_address_next_s = pmem_address_r;
        pmem_wdata_next_s   = pmem_wdata_r;
        i_rdata_next_s      = i_rdata_r;
        d_rdata_next_s      = d_rdata_r;
        i_resp_next_s       = 1'b0;
        d_resp_next_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (grant_i_s) begin
                    state_next_s        = ST_SERVE_I;
                    last_grant_d_next_s = 1'b0;
                    pmem_address_next_s = bus.i_addr;
                    pmem_read_next_s    = 1'b1;
                end else if (grant_d_s) begin
                    state_next_s        = ST_SERVE_D;
                    last_grant_d_next_s = 1'b1;
                    pmem_address_next_s = bus.d_addr;
                    if (bus.d_write) begin
                        pmem_wdata_next_s = bus.d_wdata;
                        pmem_write_next_s = 1'b1;
                    end else begin
                        pmem_read_next_s  = 1'b1;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SERVE_I: begin
                if (bus.pmem_resp) begin
                    state_next_s      = ST_DONE;
                    pmem_read_next_s  = 1'b0;
                    pmem_write_next_s = 1'b0;
                    i_rdata_next_s    = bus.pmem_rdata;
                    i_resp_next_s     = 1'b1;
                end else begin
                    state_next_s = ST_SERVE_I;
                end
            end
            ST_SERVE_D: begin
                if (bus.pmem_resp) begin
                    state_next_s      = ST_DONE;
                    pmem_read_next_s  = 1'b0;
                    pmem_write_next_s = 1'b0;
                    d_resp_next_s     = 1'b1;
                    // A writeback completion leaves the last read line in place.
                    if (pmem_write_r) begin
                        d_rdata_next_s = d_rdata_r;
                    end else begin
                        d_rdata_next_s = bus.pmem_rdata;
                    end
                end else begin
                    state_next_s = ST_SERVE_D;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s      = ST_IDLE;
                pmem_read_next_s  = 1'b0;
                pmem_write_next_s = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by rst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= ST_IDLE;
            last_grant_d_r <= 1'b1;
            pmem_read_r    <= 1'b0;
            pmem_write_r   <= 1'b0;
            pmem_address_r <= {ADDR_WIDTH{1'b0}};
            pmem_wdata_r   <= {LINE_WIDTH{1'b0}};
            i_rdata_r      <= {LINE_WIDTH{1'b0}};
            d_rdata_r      <= {LINE_WIDTH{1'b0}};
            i_resp_r       <= 1'b0;
            d_resp_r       <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            last_grant_d_r <= last_grant_d_next_s;
            pmem_read_r    <= pmem_read_next_s;
            pmem_write_r   <= pmem_write_next_s;
            pmem_address_r <= pmem_address_next_s;
            pmem_wdata_r   <= pmem_wdata_next_s;
            i_rdata_r      <= i_rdata_next_s;
            d_rdata_r      <= d_rdata_next_s;
            i_resp_r       <= i_resp_next_s;
            d_resp_r       <= d_resp_next_s;
            busy_r         <= (state_next_s != ST_IDLE);
        end
    end

    assign bus.pmem_read    = pmem_read_r;
    assign bus.pmem_write   = pmem_write_r;
    assign bus.pmem_address = pmem_address_r;
    assign bus.pmem_wdata   = pmem_wdata_r;
    assign bus.i_rdata      = i_rdata_r;
    assign bus.i_resp       = i_resp_r;
    assign bus.d_rdata      = d_rdata_r;
    assign bus.d_resp       = d_resp_r;
    assign bus.busy         = busy_r;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: single read, tie alternation, writeback,
// mid-service request changes, reset abort and zero-wait memory.
module tb_cache_mem_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;

    localparam logic [LW-1:0] PAT_A5   = {32{8'hA5}};
    localparam logic [LW-1:0] PAT_1234 = {16{16'h1234}};
    localparam logic [LW-1:0] PAT_JUNK = {8{32'hDEAD_BEEF}};

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    cache_mem_arbiter_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus ();

    cache_mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk256(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory completes this cycle with the given line; sampled at the next edge.
    task automatic mem_respond(input logic [LW-1:0] line);
        bus.pmem_rdata = line;
        bus.pmem_resp  = 1'b1;
        tick();
        bus.pmem_resp  = 1'b0;
    endtask

    task automatic chk_cmd(input string tag, input logic [AW-1:0] addr, input logic rd, input logic wr);
        chk1 ({tag, "_rd"},   bus.pmem_read, rd);
        chk1 ({tag, "_wr"},   bus.pmem_write, wr);
        chk32({tag, "_addr"}, bus.pmem_address, addr);
        chk1 ({tag, "_busy"}, bus.busy, 1'b1);
    endtask

    initial begin
        logic [LW-1:0] zline;
        logic          exp_i;
        n_cmp  = 0;
        n_fail = 0;
        rst = 1'b0;
        bus.i_read = 1'b0;  bus.i_addr = 32'h0;
        bus.d_read = 1'b0;  bus.d_write = 1'b0;  bus.d_addr = 32'h0;
        bus.d_wdata = {LW{1'b0}};
        bus.pmem_rdata = {LW{1'b0}};  bus.pmem_resp = 1'b0;

        // Reset state
        repeat (2) tick();
        chk1  ("rst_pread",  bus.pmem_read, 1'b0);
        chk1  ("rst_pwrite", bus.pmem_write, 1'b0);
        chk1  ("rst_busy",   bus.busy, 1'b0);
        chk1  ("rst_iresp",  bus.i_resp, 1'b0);
        chk1  ("rst_dresp",  bus.d_resp, 1'b0);
        chk32 ("rst_addr",   bus.pmem_address, 32'h0);
        chk256("rst_wdata",  bus.pmem_wdata, {LW{1'b0}});
        chk256("rst_irdata", bus.i_rdata, {LW{1'b0}});
        chk256("rst_drdata", bus.d_rdata, {LW{1'b0}});
        rst = 1'b1;
        tick();
        chk1("idle_busy", bus.busy, 1'b0);

        // Single I read with a 4-cycle memory
        bus.i_read = 1'b1;  bus.i_addr = 32'h0000_0060;
        tick();
        chk_cmd("i1_cmd", 32'h0000_0060, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_cmd("i1_hold", 32'h0000_0060, 1'b1, 1'b0);
            chk1("i1_noresp", bus.i_resp, 1'b0);
        end
        mem_respond(PAT_A5);
        bus.i_read = 1'b0;
        chk1  ("i1_iresp",  bus.i_resp, 1'b1);
        chk256("i1_irdata", bus.i_rdata, PAT_A5);
        chk1  ("i1_dresp",  bus.d_resp, 1'b0);
        chk1  ("i1_pread0", bus.pmem_read, 1'b0);
        chk1  ("i1_done_busy", bus.busy, 1'b1);
        tick();
        chk1  ("i1_iresp0", bus.i_resp, 1'b0);
        chk1  ("i1_idle",   bus.busy, 1'b0);
        chk256("i1_hold_rdata", bus.i_rdata, PAT_A5);

        // Fresh reset so the next tie is the first one after reset
        rst = 1'b0;  #2;  rst = 1'b1;
        tick();
        chk256("rst2_irdata", bus.i_rdata, {LW{1'b0}});

        // Tie: I first, then D, then I, then D
        bus.i_read = 1'b1;  bus.i_addr = 32'h0000_0100;
        bus.d_read = 1'b1;  bus.d_addr = 32'h0000_0200;
        tick();
        chk_cmd("tie_g1", 32'h0000_0100, 1'b1, 1'b0);
        mem_respond({8{32'h1111_0001}});
        chk1  ("tie_g1_iresp",  bus.i_resp, 1'b1);
        chk1  ("tie_g1_dresp",  bus.d_resp, 1'b0);
        chk256("tie_g1_irdata", bus.i_rdata, {8{32'h1111_0001}});
        tick();
        chk1("tie_gap_busy",  bus.busy, 1'b0);
        chk1("tie_gap_pread", bus.pmem_read, 1'b0);
        chk1("tie_gap_iresp", bus.i_resp, 1'b0);
        tick();
        chk_cmd("tie_g2", 32'h0000_0200, 1'b1, 1'b0);
        mem_respond({8{32'h2222_0002}});
        chk1  ("tie_g2_dresp",  bus.d_resp, 1'b1);
        chk1  ("tie_g2_iresp",  bus.i_resp, 1'b0);
        chk256("tie_g2_drdata", bus.d_rdata, {8{32'h2222_0002}});
        repeat (2) tick();
        chk_cmd("tie_g3", 32'h0000_0100, 1'b1, 1'b0);
        mem_respond({8{32'h3333_0003}});
        chk1  ("tie_g3_iresp",  bus.i_resp, 1'b1);
        chk256("tie_g3_irdata", bus.i_rdata, {8{32'h3333_0003}});
        repeat (2) tick();
        chk_cmd("tie_g4", 32'h0000_0200, 1'b1, 1'b0);
        mem_respond({8{32'h4444_0004}});
        bus.i_read = 1'b0;  bus.d_read = 1'b0;
        chk1  ("tie_g4_dresp",  bus.d_resp, 1'b1);
        chk256("tie_g4_drdata", bus.d_rdata, {8{32'h4444_0004}});
        tick();
        chk1("tie_end_busy", bus.busy, 1'b0);

        // D writeback with d_read also high: write wins
        bus.d_read = 1'b1;  bus.d_write = 1'b1;
        bus.d_addr = 32'h8000_0040;  bus.d_wdata = PAT_1234;
        tick();
        chk_cmd("wb_cmd", 32'h8000_0040, 1'b0, 1'b1);
        chk256 ("wb_wdata", bus.pmem_wdata, PAT_1234);
        mem_respond(PAT_JUNK);
        bus.d_read = 1'b0;  bus.d_write = 1'b0;
        chk1  ("wb_dresp",  bus.d_resp, 1'b1);
        chk1  ("wb_pwrite0", bus.pmem_write, 1'b0);
        chk256("wb_drdata_kept", bus.d_rdata, {8{32'h4444_0004}});
        tick();
        chk1("wb_dresp0", bus.d_resp, 1'b0);
        chk1("wb_idle",   bus.busy, 1'b0);

        // Requester changes during SERVE_I are ignored; D waits for DONE
        bus.i_read = 1'b1;  bus.i_addr = 32'h0000_0300;
        tick();
        chk_cmd("chg_cmd", 32'h0000_0300, 1'b1, 1'b0);
        bus.i_addr = 32'h0000_0999;
        bus.d_read = 1'b1;  bus.d_addr = 32'h0000_0400;
        tick();
        chk_cmd("chg_hold1", 32'h0000_0300, 1'b1, 1'b0);
        tick();
        chk_cmd("chg_hold2", 32'h0000_0300, 1'b1, 1'b0);
        mem_respond({8{32'h5555_0005}});
        bus.i_read = 1'b0;
        chk1  ("chg_iresp",  bus.i_resp, 1'b1);
        chk256("chg_irdata", bus.i_rdata, {8{32'h5555_0005}});
        tick();
        chk1("chg_done_pread", bus.pmem_read, 1'b0);
        chk1("chg_done_busy",  bus.busy, 1'b0);
        tick();
        chk_cmd("chg_dgrant", 32'h0000_0400, 1'b1, 1'b0);

        // Reset in SERVE_D: outputs clear asynchronously, stray resp ignored
        #1;  rst = 1'b0;  #1;
        chk1  ("abort_pread", bus.pmem_read, 1'b0);
        chk32 ("abort_addr",  bus.pmem_address, 32'h0);
        chk1  ("abort_busy",  bus.busy, 1'b0);
        chk256("abort_drdata", bus.d_rdata, {LW{1'b0}});
        bus.d_read = 1'b0;
        #2;  rst = 1'b1;
        mem_respond(PAT_JUNK);
        chk1("abort_dresp", bus.d_resp, 1'b0);
        chk1("abort_busy2", bus.busy, 1'b0);
        chk1("abort_pread2", bus.pmem_read, 1'b0);
        tick();
        chk1("abort_dresp2", bus.d_resp, 1'b0);

        // Zero-wait memory with both sides requesting: I, D, I, D every 3 cycles
        bus.i_read = 1'b1;  bus.i_addr = 32'h0000_0500;
        bus.d_read = 1'b1;  bus.d_addr = 32'h0000_0600;
        tick();
        chk_cmd("zw_g0", 32'h0000_0500, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            exp_i = ((k % 2) == 0);
            zline = {8{32'hC0DE_0000 + 32'(k)}};
            mem_respond(zline);
            if (k == 3) begin
                bus.i_read = 1'b0;  bus.d_read = 1'b0;
            end
            chk1("zw_iresp", bus.i_resp, exp_i);
            chk1("zw_dresp", bus.d_resp, ~exp_i);
            if (exp_i) chk256("zw_irdata", bus.i_rdata, zline);
            else       chk256("zw_drdata", bus.d_rdata, zline);
            tick();
            chk1("zw_iresp_w", bus.i_resp, 1'b0);
            chk1("zw_dresp_w", bus.d_resp, 1'b0);
            chk1("zw_gap_busy", bus.busy, 1'b0);
            tick();
            if (k < 3) chk_cmd("zw_gn", exp_i ? 32'h0000_0600 : 32'h0000_0500, 1'b1, 1'b0);
            else       chk1("zw_end_busy", bus.busy, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
